// File: rtl/dtc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dtc_pkg                                                         |
// | Brief    : Shared types and constants for the decision-tree vote stages.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package dtc_pkg;

  typedef logic [1:0] dtc_class_t;

  localparam int DTC_NUM_CLASSES = 4;

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } dtc_vote_state_e;

  // Counter width able to hold the value n (0..n inclusive).
  function automatic int dtc_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dtc_argmax4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dtc_argmax4                                                     |
// | Brief    : Combinational 4-way argmax, lowest index wins ties, tie flag.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dtc_argmax4
  import dtc_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic [CNT_W-1:0] cnt0,
  input  logic [CNT_W-1:0] cnt1,
  input  logic [CNT_W-1:0] cnt2,
  input  logic [CNT_W-1:0] cnt3,
  output logic [1:0]       win_idx,
  output logic [CNT_W-1:0] win_cnt,
  output logic             win_tie
);

  logic [CNT_W-1:0] w_cnt [DTC_NUM_CLASSES];

  assign w_cnt[0] = cnt0;
  assign w_cnt[1] = cnt1;
  assign w_cnt[2] = cnt2;
  assign w_cnt[3] = cnt3;

  // Strict greater-than keeps the earliest (lowest) index on equal counts.
  always_comb begin
    win_idx = 2'd0;
    win_cnt = w_cnt[0];
    for (int k = 1; k < DTC_NUM_CLASSES; k++) begin
      if (w_cnt[k] > win_cnt) begin
        win_idx = 2'(k);
        win_cnt = w_cnt[k];
      end
    end
  end

  always_comb begin
    win_tie = 1'b0;
    for (int k = 0; k < DTC_NUM_CLASSES; k++) begin
      if ((2'(k) != win_idx) && (w_cnt[k] == win_cnt)) begin
        win_tie = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dtc_vote_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dtc_vote_accum                                                  |
// | Brief    : Windowed majority vote over classifier predictions.             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dtc_vote_accum
  import dtc_pkg::*;
#(
  parameter  int WINDOW = 16,
  localparam int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_class,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_class,
  output logic [CNT_W-1:0] out_count,
  output logic             out_tie
);

  dtc_vote_state_e  r_state;
  dtc_vote_state_e  w_state_nxt;

  logic [CNT_W-1:0] r_vote     [DTC_NUM_CLASSES];
  logic [CNT_W-1:0] w_vote_nxt [DTC_NUM_CLASSES];
  logic [CNT_W-1:0] r_samples;

  logic             w_accept;
  logic             w_last;
  logic             w_flush;

  logic [1:0]       w_win_idx;
  logic [CNT_W-1:0] w_win_cnt;
  logic             w_win_tie;

  logic [1:0]       r_out_class;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_tie;

  // clear outranks both the input accept and the output handshake.
  assign w_accept = in_valid && !clear && (r_state == ACCUM);
  assign w_last   = (r_samples == CNT_W'(WINDOW - 1));
  assign w_flush  = clear || ((r_state == REPORT) && out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready = rst_n;
        if (!clear && w_accept && w_last) begin
          w_state_nxt = REPORT;
        end
      end
      REPORT: begin
        out_valid = 1'b1;
        if (clear || out_ready) begin
          w_state_nxt = ACCUM;
        end
      end
      default: begin
        w_state_nxt = ACCUM;
      end
    endcase
  end

  // in_class only influences the sum when the sample is actually accepted.
  always_comb begin
    for (int k = 0; k < DTC_NUM_CLASSES; k++) begin
      w_vote_nxt[k] = r_vote[k] + CNT_W'(w_accept && (in_class == 2'(k)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DTC_NUM_CLASSES; k++) begin
        r_vote[k] <= '0;
      end
      r_samples <= '0;
    end else if (w_flush) begin
      for (int k = 0; k < DTC_NUM_CLASSES; k++) begin
        r_vote[k] <= '0;
      end
      r_samples <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < DTC_NUM_CLASSES; k++) begin
        r_vote[k] <= w_vote_nxt[k];
      end
      r_samples <= r_samples + CNT_W'(1);
    end
  end

  // Argmax sees the counts including the sample that closes the window.
  dtc_argmax4 #(
    .CNT_W (CNT_W)
  ) u_argmax (
    .cnt0    (w_vote_nxt[0]),
    .cnt1    (w_vote_nxt[1]),
    .cnt2    (w_vote_nxt[2]),
    .cnt3    (w_vote_nxt[3]),
    .win_idx (w_win_idx),
    .win_cnt (w_win_cnt),
    .win_tie (w_win_tie)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_class <= '0;
      r_out_count <= '0;
      r_out_tie   <= 1'b0;
    end else if (w_accept && w_last) begin
      r_out_class <= w_win_idx;
      r_out_count <= w_win_cnt;
      r_out_tie   <= w_win_tie;
    end
  end

  assign out_class = r_out_class;
  assign out_count = r_out_count;
  assign out_tie   = r_out_tie;

endmodule
`default_nettype wire

// File: tb/tb_dtc_vote_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dtc_vote_accum                                               |
// | Brief    : Scoreboard bench for dtc_vote_accum (WINDOW=4 and WINDOW=1).    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_dtc_vote_accum;

  typedef struct packed {
    logic [1:0] c;
    logic [7:0] n;
    logic       t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_class;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_class;
  logic [2:0] out_count;
  logic       out_tie;

  logic       d1_in_valid;
  logic       d1_in_ready;
  logic [1:0] d1_in_class;
  logic       d1_out_valid;
  logic       d1_out_ready;
  logic [1:0] d1_out_class;
  logic [0:0] d1_out_count;
  logic       d1_out_tie;

  exp_t q  [$];
  exp_t q1 [$];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dtc_vote_accum #(.WINDOW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_count (out_count),
    .out_tie   (out_tie)
  );

  dtc_vote_accum #(.WINDOW(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (1'b0),
    .in_valid  (d1_in_valid),
    .in_ready  (d1_in_ready),
    .in_class  (d1_in_class),
    .out_valid (d1_out_valid),
    .out_ready (d1_out_ready),
    .out_class (d1_out_class),
    .out_count (d1_out_count),
    .out_tie   (d1_out_tie)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitors: every cycle a result is presented it must match the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_result", {21'b0, out_class, 5'b0, out_count, out_tie}, 32'hFFFF_FFFF);
      end else begin
        chk("result{class,count,tie}", {21'b0, out_class, 5'b0, out_count, out_tie}, {21'b0, q[0]});
        if (out_ready || clear) void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q1.delete();
    end else if (d1_out_valid) begin
      if (q1.size() == 0) begin
        chk("w1_unexpected_result", {21'b0, d1_out_class, 7'b0, d1_out_count, d1_out_tie}, 32'hFFFF_FFFF);
      end else begin
        chk("w1_result{class,count,tie}", {21'b0, d1_out_class, 7'b0, d1_out_count, d1_out_tie}, {21'b0, q1[0]});
        if (d1_out_ready) void'(q1.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [1:0] c);
    in_valid = v;
    in_class = c;
    step();
    in_valid = 1'b0;
    in_class = 2'bxx;
  endtask

  task automatic push(input logic [1:0] c, input logic [7:0] n, input logic t);
    q.push_back('{c: c, n: n, t: t});
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] cls [4];

    rst_n        = 1'b0;
    clear        = 1'b0;
    in_valid     = 1'b0;
    in_class     = 2'b00;
    out_ready    = 1'b1;
    d1_in_valid  = 1'b0;
    d1_in_class  = 2'b00;
    d1_out_ready = 1'b1;

    repeat (2) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", {out_class, out_count, out_tie}, 0);
    chk("w1_rst_out_valid", d1_out_valid, 0);

    @(negedge clk) rst_n = 1'b1;
    step();
    chk("in_ready_after_reset", in_ready, 1);
    chk("w1_in_ready_after_reset", d1_in_ready, 1);

    // Basic majority with latency and in_ready checks.
    push(2, 3, 0);
    cyc(1, 2); cyc(1, 2); cyc(1, 1);
    chk("no_result_before_window", out_valid, 0);
    cyc(1, 2);
    chk("valid_one_cycle_after_last", out_valid, 1);
    chk("in_ready_in_report", in_ready, 0);
    step();
    chk("in_ready_after_handshake", in_ready, 1);
    chk("valid_drop_after_handshake", out_valid, 0);

    // WINDOW=1: every accept is a complete window.
    cls = '{2'd0, 2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 4; i++) begin
      q1.push_back('{c: cls[i], n: 8'd1, t: 1'b0});
      d1_in_valid = 1'b1;
      d1_in_class = cls[i];
      step();
      d1_in_valid = 1'b0;
      chk("w1_valid_after_accept", d1_out_valid, 1);
      step();
    end

    // Tie-break cases.
    push(1, 2, 1);
    cyc(1, 3); cyc(1, 1); cyc(1, 3); cyc(1, 1);
    step();
    push(0, 1, 1);
    cyc(1, 0); cyc(1, 1); cyc(1, 2); cyc(1, 3);
    step();

    // Backpressure: result held, extra inputs ignored.
    out_ready = 1'b0;
    push(0, 4, 0);
    cyc(1, 0); cyc(1, 0); cyc(1, 0); cyc(1, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid_high", out_valid, 1);
    end
    out_ready = 1'b1;
    step();
    push(2, 2, 0);
    cyc(1, 1); cyc(1, 2); cyc(1, 2); cyc(1, 3);
    step();

    // Bubbles with don't-care class between accepts.
    push(3, 3, 0);
    cyc(1, 3); cyc(0, 2'bxx); cyc(0, 2'bxx); cyc(1, 3);
    cyc(0, 2'bxx); cyc(1, 0); cyc(1, 3);
    step();

    // clear during accumulation drops the partial window and the coincident sample.
    cyc(1, 3); cyc(1, 3); cyc(1, 3);
    clear = 1'b1;
    cyc(1, 3);
    clear = 1'b0;
    chk("clear_no_result", out_valid, 0);
    push(1, 2, 0);
    cyc(1, 1); cyc(1, 1); cyc(1, 0); cyc(1, 2);
    step();

    // clear during REPORT together with out_ready.
    out_ready = 1'b0;
    push(2, 4, 0);
    cyc(1, 2); cyc(1, 2); cyc(1, 2); cyc(1, 2);
    step();
    clear     = 1'b1;
    out_ready = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_report_valid_low", out_valid, 0);
    chk("clear_report_in_ready", in_ready, 1);

    // Asynchronous reset while a result is pending.
    out_ready = 1'b0;
    push(1, 4, 0);
    cyc(1, 1); cyc(1, 1); cyc(1, 1); cyc(1, 1);
    chk("pre_reset_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid_low", out_valid, 0);
    chk("async_reset_in_ready_low", in_ready, 0);
    step();
    @(negedge clk) rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    push(2, 4, 0);
    cyc(1, 2); cyc(1, 2); cyc(1, 2); cyc(1, 2);
    step();

    repeat (3) step();
    chk("scoreboard_drained", q.size(), 0);
    chk("w1_scoreboard_drained", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dtc_vote_accum.md
Name: dtc_vote_accum

Overview:
- Downstream consumer of the 8-input / 2-bit-class decision-tree classifier stage.
- Accepts one class prediction per handshake and accumulates per-class vote counts over a fixed window of WINDOW samples.
- At the end of each window, emits the majority class, its vote count and a tie flag.
- Smooths per-sample classifier noise before the result reaches the system-level consumer.

Parameters:
- WINDOW, 16, number of accepted predictions per decision window; legal range 1..255.
- CNT_W, $clog2(WINDOW+1), width of the vote and sample counters; derived, not overridden.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort: discard the current window and any pending result.
- in_valid  input  1  in_class is valid.
- in_ready  output  1  block can accept a prediction.
- in_class  input  2  class prediction from the classifier (0..3).
- out_valid  output  1  window result is valid.
- out_ready  input  1  downstream accepts the result.
- out_class  output  2  majority class of the completed window.
- out_count  output  CNT_W  vote count of out_class.
- out_tie  output  1  at least one other class has a count equal to out_count.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=ACCUM; all four vote counters and the sample counter = 0.
  - out_valid=0, out_class=0, out_count=0, out_tie=0.
  - in_ready reads 0 while rst_n=0 and 1 from the first cycle after deassertion.
- States: ACCUM, REPORT.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Accept: in_valid & in_ready on a rising edge → vote[in_class]+=1 and samples+=1.
  - When an accept makes samples==WINDOW, the next edge loads out_class/out_count/out_tie from the argmax of the updated counts, sets out_valid=1 and enters REPORT.
  - Latency: result visible one cycle after the WINDOW-th accept.
- REPORT:
  - in_ready=0; out_valid=1.
  - out_class, out_count and out_tie are held stable until out_valid & out_ready.
  - On handshake: next edge clears all counters, drops out_valid and returns to ACCUM. in_ready=1 in the cycle after the handshake, so no sample is accepted in the handshake cycle.
- Argmax:
  - Highest count wins.
  - Ties resolve to the lowest class index.
  - out_tie=1 iff some other class index has an equal count.
  - WINDOW=1 → out_count=1 and out_tie=0.
- Counters:
  - Vote counters cannot exceed WINDOW and never wrap.
  - The sample counter resets to 0 at each window start.
- clear:
  - Has priority over accept and over output handshake in the same cycle.
  - Next edge: counters=0, state=ACCUM, out_valid=0.
  - Output data registers keep their old values; they are don't-care while out_valid=0.
  - A prediction presented with clear=1 is not counted, even if in_ready=1.
- Reset mid-window or during REPORT: all state lost immediately; no partial result is emitted.
- in_class is sampled only on an accept. X on in_class while in_valid=0 must not propagate.

Decomposition:
- Shared package dtc_pkg:
  - typedef dtc_class_t (logic [1:0]).
  - constant DTC_NUM_CLASSES=4.
  - state enum dtc_vote_state_e {ACCUM, REPORT}.
- Sub-module dtc_argmax4: purely combinational.
  - Inputs: four CNT_W-bit counts.
  - Outputs: winning index, winning count, tie flag.
  - Implements the lowest-index tie-break.
  - Instantiated once; reusable by other ensemble/vote stages.

Test Plan (WINDOW=4 unless stated):
- Basic majority: accept classes 2,2,1,2 back-to-back, out_ready=1 → one cycle after the 4th accept: out_valid=1, out_class=2, out_count=3, out_tie=0; in_ready=0 during REPORT, back to 1 the cycle after the handshake.
- Tie-break: classes 3,1,3,1 → out_class=1, out_count=2, out_tie=1; four distinct classes 0,1,2,3 → out_class=0, out_count=1, out_tie=1.
- Backpressure: complete window 0,0,0,0 with out_ready=0 for 10 cycles → out_valid stays 1 with out_class=0 and out_count=4 stable, in_ready=0, extra in_valid pulses ignored; raising out_ready → result consumed; next window starts from zero counts.
- Bubbles: in_valid toggled 1,0,0,1,0,1,1 with classes 3,x,x,3,x,0,3 → only 4 accepts counted; out_class=3, out_count=3.
- clear: after accepting 3,3,3, assert clear together with in_valid (class 3) → no result emitted; then classes 1,1,0,2 → out_class=1, out_count=2. clear asserted during REPORT together with out_ready → out_valid=0 next cycle, state ACCUM.
- Async reset: assert rst_n=0 mid-cycle during REPORT → out_valid=0 immediately without a clock edge; after release, a fresh window 2,2,2,2 yields out_class=2, out_count=4. WINDOW=1 build: each accept yields a result with out_count=1, out_tie=0.
